// File: rtl/sha_math_core_par.sv
// SHA-256 compression core, ROUNDS_PER_CYCLE rounds per clock, chaining H across jobs.
// A job starts from the built-in IV, an external IV or the previous digest, and can be aborted while rounds run.
module sha_math_core_par #(
  parameter int ROUNDS_PER_CYCLE = 1
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         first_state,
  input  logic         next_state,
  input  logic         use_std_iv,
  input  logic [255:0] initial_state,
  input  logic [511:0] message_block,
  input  logic         abort,
  output logic         status,
  output logic [255:0] block_digester,
  output logic         valid_block
);

  if (!(ROUNDS_PER_CYCLE == 1 || ROUNDS_PER_CYCLE == 2 ||
        ROUNDS_PER_CYCLE == 4 || ROUNDS_PER_CYCLE == 8)) begin : g_bad_rounds
    $error("sha_math_core_par: ROUNDS_PER_CYCLE must be 1, 2, 4 or 8");
  end

  typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_ROUNDS = 2'd1, ST_FINAL = 2'd2} state_t;

  localparam logic [6:0] R_STEP = 7'(ROUNDS_PER_CYCLE);

  // Index 0 holds H0; matches the initial_state word order.
  localparam logic [7:0][31:0] STD_IV = {
    32'h5be0cd19, 32'h1f83d9ab, 32'h9b05688c, 32'h510e527f,
    32'ha54ff53a, 32'h3c6ef372, 32'hbb67ae85, 32'h6a09e667};

  localparam logic [0:63][31:0] K_TAB = {
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2};

  function automatic logic [31:0] big_sigma0(input logic [31:0] x);
    return {x[1:0], x[31:2]} ^ {x[12:0], x[31:13]} ^ {x[21:0], x[31:22]};
  endfunction

  function automatic logic [31:0] big_sigma1(input logic [31:0] x);
    return {x[5:0], x[31:6]} ^ {x[10:0], x[31:11]} ^ {x[24:0], x[31:25]};
  endfunction

  function automatic logic [31:0] small_sigma0(input logic [31:0] x);
    return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ {3'b000, x[31:3]};
  endfunction

  function automatic logic [31:0] small_sigma1(input logic [31:0] x);
    return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ {10'b0000000000, x[31:10]};
  endfunction

  function automatic logic [31:0] ch(input logic [31:0] e, input logic [31:0] f, input logic [31:0] g);
    return (e & f) ^ (~e & g);
  endfunction

  function automatic logic [31:0] maj(input logic [31:0] a, input logic [31:0] b, input logic [31:0] c);
    return (a & b) ^ (a & c) ^ (b & c);
  endfunction

  state_t            state_r, state_nxt_s;
  logic [7:0][31:0]  h_r, work_r, work_s, chain_s, h_sum_s;
  logic [15:0][31:0] win_r, win_s, msg_s;
  logic [6:0]        cnt_r;
  logic [255:0]      digest_r, digest_s;
  logic              status_r, valid_r, start_s, last_s;
  logic [31:0]       t1_s, t2_s, new_w_s;
  logic [5:0]        idx_s;

  // Start-time chain value, message unpacking and the final feed-forward sum.
  always_comb begin
    chain_s  = h_r;
    msg_s    = 512'd0;
    digest_s = 256'd0;
    if (first_state) begin
      if (use_std_iv) chain_s = STD_IV;
      else            chain_s = initial_state;
    end else begin
      chain_s = h_r;
    end
    for (int i = 0; i < 16; i++) msg_s[i] = message_block[511-32*i -: 32];
    for (int i = 0; i < 8; i++) begin
      h_sum_s[i] = h_r[i] + work_r[i];
      digest_s[255-32*i -: 32] = h_sum_s[i];
    end
  end

  // Unrolled rounds; the 16-word window yields W[t] at slot 0 and extends W on the fly.
  always_comb begin
    work_s  = work_r;
    win_s   = win_r;
    t1_s    = 32'd0;
    t2_s    = 32'd0;
    new_w_s = 32'd0;
    idx_s   = cnt_r[5:0];
    for (int i = 0; i < ROUNDS_PER_CYCLE; i++) begin
      idx_s   = cnt_r[5:0] + 6'(i);
      t1_s    = work_s[7] + big_sigma1(work_s[4]) + ch(work_s[4], work_s[5], work_s[6]) +
                K_TAB[idx_s] + win_s[0];
      t2_s    = big_sigma0(work_s[0]) + maj(work_s[0], work_s[1], work_s[2]);
      new_w_s = small_sigma1(win_s[14]) + win_s[9] + small_sigma0(win_s[1]) + win_s[0];
      work_s  = {work_s[6:4], work_s[3] + t1_s, work_s[2:0], t1_s + t2_s};
      win_s   = {new_w_s, win_s[15:1]};
    end
  end

  // Next-state logic.
  always_comb begin
    state_nxt_s = state_r;
    start_s     = 1'b0;
    last_s      = ((cnt_r + R_STEP) == 7'd64);
    case (state_r)
      ST_IDLE: begin
        if (first_state || next_state) begin
          start_s     = 1'b1;
          state_nxt_s = ST_ROUNDS;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_ROUNDS: begin
        if (abort)       state_nxt_s = ST_IDLE;
        else if (last_s) state_nxt_s = ST_FINAL;
        else             state_nxt_s = ST_ROUNDS;
      end
      ST_FINAL: state_nxt_s = ST_IDLE;
      default:  state_nxt_s = ST_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!reset_n) state_r <= ST_IDLE;
    else          state_r <= state_nxt_s;
  end

  // Datapath and registered outputs.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      h_r      <= 256'd0;
      work_r   <= 256'd0;
      win_r    <= 512'd0;
      cnt_r    <= 7'd0;
      digest_r <= 256'd0;
      status_r <= 1'b1;
      valid_r  <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (start_s) begin
            win_r    <= msg_s;
            work_r   <= chain_s;
            h_r      <= chain_s;
            cnt_r    <= 7'd0;
            valid_r  <= 1'b0;
            status_r <= 1'b0;
          end
        end
        ST_ROUNDS: begin
          if (abort) begin
            status_r <= 1'b1;
          end else begin
            work_r <= work_s;
            win_r  <= win_s;
            cnt_r  <= cnt_r + R_STEP;
          end
        end
        ST_FINAL: begin
          h_r      <= h_sum_s;
          digest_r <= digest_s;
          valid_r  <= 1'b1;
          status_r <= 1'b1;
        end
        default: status_r <= 1'b1;
      endcase
    end
  end

  assign status         = status_r;
  assign valid_block    = valid_r;
  assign block_digester = digest_r;

endmodule

// File: tb/tb_sha_math_core_par.sv
// Bench for sha_math_core_par: four instances (R=1,2,4,8) share stimulus and are checked
// against a textbook SHA-256 compression model with a per-instance chain value.
module tb_sha_math_core_par;

  localparam logic [255:0] STD_IV_D = 256'h6a09e667bb67ae853c6ef372a54ff53a510e527f9b05688c1f83d9ab5be0cd19;
  localparam logic [255:0] T1_IV    = 256'h5be0cd19_1f83d9ab_9b05688c_510e527f_a54ff53a_3c6ef372_bb67ae85_6a09e667;
  localparam logic [255:0] ABC_DIG  = 256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;
  localparam logic [255:0] D1_DIG   = 256'h85e655d6417a17953363376a624cde5c76e09589cac5f811cc4b32c1f20e533a;
  localparam logic [255:0] D2_DIG   = 256'h248d6a61d20638b8e5c026930c3e6039a33ce45964ff2167f6ecedd419db06c1;
  localparam logic [511:0] ABC_BLK  = {32'h61626380, 448'd0, 32'h00000018};
  localparam logic [511:0] B1_BLK   = {32'h61626364, 32'h62636465, 32'h63646566, 32'h64656667,
                                       32'h65666768, 32'h66676869, 32'h6768696a, 32'h68696a6b,
                                       32'h696a6b6c, 32'h6a6b6c6d, 32'h6b6c6d6e, 32'h6c6d6e6f,
                                       32'h6d6e6f70, 32'h6e6f7071, 32'h80000000, 32'h00000000};
  localparam logic [511:0] B2_BLK   = {448'd0, 32'h00000000, 32'h000001c0};

  localparam logic [31:0] KREF [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2};

  logic         clk = 1'b0;
  logic         reset_n, first_state, next_state, use_std_iv, abort;
  logic [255:0] initial_state;
  logic [511:0] message_block;
  logic         status_w [4];
  logic         valid_w  [4];
  logic [255:0] dig_w    [4];

  int           checks = 0;
  int           failures = 0;
  logic [255:0] mh   [4];
  logic [255:0] mdig [4];

  always #5 clk = ~clk;

  for (genvar g = 0; g < 4; g++) begin : g_dut
    sha_math_core_par #(.ROUNDS_PER_CYCLE(1 << g)) u_dut (
      .clk(clk), .reset_n(reset_n), .first_state(first_state), .next_state(next_state),
      .use_std_iv(use_std_iv), .initial_state(initial_state), .message_block(message_block),
      .abort(abort), .status(status_w[g]), .block_digester(dig_w[g]), .valid_block(valid_w[g]));
  end

  function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  // Reference compression; chain and result in digest word order (H0 at the top).
  function automatic logic [255:0] ref_compress(input logic [255:0] hin, input logic [511:0] blk);
    logic [31:0] w [64];
    logic [31:0] v [8];
    logic [31:0] hh [8];
    logic [31:0] t1, t2, s0, s1;
    logic [255:0] r;
    for (int i = 0; i < 8; i++) begin hh[i] = hin[255-32*i -: 32]; v[i] = hh[i]; end
    for (int i = 0; i < 16; i++) w[i] = blk[511-32*i -: 32];
    for (int i = 16; i < 64; i++) begin
      s0 = rotr(w[i-15], 7) ^ rotr(w[i-15], 18) ^ (w[i-15] >> 3);
      s1 = rotr(w[i-2], 17) ^ rotr(w[i-2], 19) ^ (w[i-2] >> 10);
      w[i] = s1 + w[i-7] + s0 + w[i-16];
    end
    for (int t = 0; t < 64; t++) begin
      t1 = v[7] + (rotr(v[4], 6) ^ rotr(v[4], 11) ^ rotr(v[4], 25)) +
           ((v[4] & v[5]) ^ (~v[4] & v[6])) + KREF[t] + w[t];
      t2 = (rotr(v[0], 2) ^ rotr(v[0], 13) ^ rotr(v[0], 22)) +
           ((v[0] & v[1]) ^ (v[0] & v[2]) ^ (v[1] & v[2]));
      v[7] = v[6]; v[6] = v[5]; v[5] = v[4]; v[4] = v[3] + t1;
      v[3] = v[2]; v[2] = v[1]; v[1] = v[0]; v[0] = t1 + t2;
    end
    for (int i = 0; i < 8; i++) r[255-32*i -: 32] = hh[i] + v[i];
    return r;
  endfunction

  function automatic logic [255:0] iv_swap(input logic [255:0] x);
    logic [255:0] r;
    for (int i = 0; i < 8; i++) r[255-32*i -: 32] = x[32*i +: 32];
    return r;
  endfunction

  function automatic logic [255:0] rand256();
    logic [255:0] r;
    for (int i = 0; i < 8; i++) r[32*i +: 32] = $urandom();
    return r;
  endfunction

  function automatic logic [511:0] rand512();
    logic [511:0] r;
    for (int i = 0; i < 16; i++) r[32*i +: 32] = $urandom();
    return r;
  endfunction

  // Called at a negedge; drives one start, optional abort/busy-start pulses, checks every instance.
  task automatic run_job(input string name, input bit f, input bit n, input bit std,
                         input logic [255:0] iv, input logic [511:0] blk,
                         input int abort_at, input int poke_at);
    logic [255:0] chain [4];
    int  low [4];
    bit  ab [4];
    int  c;
    bit  busy;
    for (int k = 0; k < 4; k++) begin
      chain[k] = f ? (std ? STD_IV_D : iv_swap(iv)) : mh[k];
      ab[k]    = (abort_at >= 1) && (abort_at <= (64 >> k));
      low[k]   = 0;
    end
    first_state = f; next_state = n; use_std_iv = std;
    initial_state = iv; message_block = blk; abort = (abort_at == 0);
    c = 0;
    do begin
      @(negedge clk);
      c++;
      first_state = (c == poke_at);
      next_state  = 1'b0;
      abort       = (c == abort_at);
      if (c == poke_at) begin
        initial_state = rand256(); message_block = rand512(); use_std_iv = $urandom_range(0, 1) == 1;
      end
      busy = 1'b0;
      for (int k = 0; k < 4; k++) if (status_w[k] !== 1'b1) begin low[k]++; busy = 1'b1; end
    end while ((busy || c <= abort_at || c <= poke_at) && c < 200);
    first_state = 1'b0; abort = 1'b0;
    checks++;
    if (busy) begin
      failures++;
      $display("FAIL %s timeout: status still low after %0d cycles, required high", name, c);
    end
    for (int k = 0; k < 4; k++) begin
      if (!ab[k]) begin mdig[k] = ref_compress(chain[k], blk); mh[k] = mdig[k]; end
      else        mh[k] = chain[k];
      checks++;
      if (low[k] !== (ab[k] ? abort_at : (64 >> k) + 1)) begin
        failures++;
        $display("FAIL %s R=%0d busy_cycles got=%0d exp=%0d", name, 1 << k, low[k],
                 ab[k] ? abort_at : (64 >> k) + 1);
      end
      checks++;
      if (valid_w[k] !== !ab[k]) begin
        failures++;
        $display("FAIL %s R=%0d valid_block got=%b exp=%b", name, 1 << k, valid_w[k], !ab[k]);
      end
      checks++;
      if (dig_w[k] !== mdig[k]) begin
        failures++;
        $display("FAIL %s R=%0d digest got=%h exp=%h", name, 1 << k, dig_w[k], mdig[k]);
      end
    end
  endtask

  task automatic check_known(input string name, input logic [255:0] exp, input int kmax);
    for (int k = 0; k < kmax; k++) begin
      checks++;
      if (dig_w[k] !== exp) begin
        failures++;
        $display("FAIL %s R=%0d known_digest got=%h exp=%h", name, 1 << k, dig_w[k], exp);
      end
    end
  endtask

  task automatic check_cleared(input string name);
    for (int k = 0; k < 4; k++) begin
      mh[k] = 256'd0; mdig[k] = 256'd0;
      checks++;
      if (status_w[k] !== 1'b1 || valid_w[k] !== 1'b0 || dig_w[k] !== 256'd0) begin
        failures++;
        $display("FAIL %s R=%0d status/valid/digest got=%b/%b/%h exp=1/0/0", name, 1 << k,
                 status_w[k], valid_w[k], dig_w[k]);
      end
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0; first_state = 1'b0; next_state = 1'b0; use_std_iv = 1'b0;
    abort = 1'b0; initial_state = 256'd0; message_block = 512'd0;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    check_cleared("reset");
    run_job("next_from_zero", 1'b0, 1'b1, 1'b0, rand256(), rand512(), -1, -1);
  endtask

  task automatic test_ext_iv(input string name);
    run_job(name, 1'b1, 1'b0, 1'b0, T1_IV, ABC_BLK, -1, -1);
    check_known(name, ABC_DIG, 4);
  endtask

  task automatic test_std_iv();
    run_job("std_iv_abc", 1'b1, 1'b0, 1'b1, 256'd0, ABC_BLK, -1, -1);
    check_known("std_iv_abc", ABC_DIG, 4);
  endtask

  task automatic test_two_block();
    run_job("two_block_1", 1'b1, 1'b0, 1'b1, 256'd0, B1_BLK, -1, -1);
    check_known("two_block_1", D1_DIG, 4);
    run_job("two_block_2", 1'b0, 1'b1, 1'b0, rand256(), B2_BLK, -1, -1);
    check_known("two_block_2", D2_DIG, 4);
  endtask

  // R=8 finishes before cycle 10, so only R=1,2,4 see the abort.
  task automatic test_abort();
    run_job("abort_blk1", 1'b1, 1'b0, 1'b1, 256'd0, B1_BLK, -1, -1);
    run_job("abort_blk2", 1'b0, 1'b1, 1'b0, 256'd0, B2_BLK, 10, -1);
    run_job("abort_reissue", 1'b0, 1'b1, 1'b0, 256'd0, B2_BLK, -1, -1);
    check_known("abort_reissue", D2_DIG, 3);
  endtask

  task automatic test_busy_start();
    run_job("start_while_busy", 1'b1, 1'b0, 1'b1, 256'd0, ABC_BLK, -1, 3);
    check_known("start_while_busy", ABC_DIG, 4);
    run_job("first_wins", 1'b1, 1'b1, 1'b1, 256'd0, ABC_BLK, -1, -1);
    check_known("first_wins", ABC_DIG, 4);
    run_job("abort_with_start", 1'b1, 1'b0, 1'b1, 256'd0, ABC_BLK, 0, -1);
    check_known("abort_with_start", ABC_DIG, 4);
  endtask

  task automatic test_reset_mid();
    first_state = 1'b1; use_std_iv = 1'b1; message_block = ABC_BLK;
    @(negedge clk);
    first_state = 1'b0;
    repeat (29) @(negedge clk);
    reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    check_cleared("reset_mid_job");
  endtask

  // Consecutive jobs start on the edge right after the slowest instance goes idle.
  task automatic test_back_to_back();
    for (int j = 0; j < 10; j++) begin
      bit f, n, s;
      int ab_at;
      f = $urandom_range(0, 1) == 1;
      n = !f || ($urandom_range(0, 1) == 1);
      s = $urandom_range(0, 1) == 1;
      case ($urandom_range(0, 2))
        0:       ab_at = -1;
        1:       ab_at = 0;
        default: ab_at = int'($urandom_range(1, 40));
      endcase
      run_job("random_b2b", f, n, s, rand256(), rand512(), ab_at, -1);
    end
  endtask

  initial begin
    test_reset();
    test_ext_iv("ext_iv_abc");
    test_std_iv();
    test_two_block();
    test_abort();
    test_busy_start();
    test_reset_mid();
    test_ext_iv("ext_iv_after_reset");
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
